// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Shared opcode defines (RV32 major opcodes used by the scoreboard) and the
//   default result latency per opcode class, i.e. the number of cycles between
//   an instruction leaving ID and its result reaching the forwarding point.
//   No ports; imported by hazard_scoreboard and available to benches.
// ---------------------------------------------------------------------------
`ifndef HAZARD_SCOREBOARD_OPCODES
`define HAZARD_SCOREBOARD_OPCODES
`define OPC_LOAD   7'b0000011
`define OPC_STORE  7'b0100011
`define OPC_BRANCH 7'b1100011
`define OPC_OP     7'b0110011
`endif

package hazard_scoreboard_pkg;

    // Default forwarding latency per opcode class (ID issues issue_lat from these).
    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = 4;

    // Branches and stores carry an rd-shaped field that is not a destination.
    function automatic logic writes_rd(input logic [6:0] opcode);
        return (opcode != `OPC_BRANCH) && (opcode != `OPC_STORE);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// ---------------------------------------------------------------------------
// sb_entry
//   One scoreboard slot: pending bit plus a saturating countdown to the cycle
//   the register's result becomes forwardable.
//   Ports:
//     clk, rst_n  - clock, synchronous active-low reset
//     set/set_lat - new producer issued for this register with its latency
//     clr         - writeback retires this register
//     flush       - squash entries whose result is still in flight
//     pending/cnt - current state
// ---------------------------------------------------------------------------
module sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set,
    input  logic [LAT_W-1:0] set_lat,
    input  logic             clr,
    input  logic             flush,
    output logic             pending,
    output logic [LAT_W-1:0] cnt
);

    logic             pending_q, pending_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        pending_d = pending_q;
        cnt_d     = (cnt_q != '0) ? cnt_q - LAT_W'(1) : '0;
        if (clr) begin
            pending_d = 1'b0;
        end
        // Flush looks at the pre-decrement count and overrides a same-cycle
        // issue; an issue otherwise overrides a same-cycle retire.
        if (flush) begin
            if (cnt_q != '0) begin
                pending_d = 1'b0;
            end
        end else if (set) begin
            pending_d = 1'b1;
            cnt_d     = set_lat;
        end
        // Idle slots keep a zero count so a later flush test is trivially clean.
        if (!pending_d) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending = pending_q;
    assign cnt     = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Tracks in-flight destination registers whose results are not yet
//   forwardable and stalls ID when a used source operand depends on one.
//   Ports:
//     clk, rst_n            - clock, synchronous active-low reset
//     issue_*               - instruction leaving ID (opcode, rd, latency)
//     rs1/rs2_addr, _used   - ID source operands
//     wb_valid, wb_rd       - register writeback (retire)
//     flush                 - squash of younger instructions
//     stall                 - combinational hold of IF/ID, bubble into EX
//     busy                  - per-register pending vector (bit 0 always 0)
//     stall_cycles          - stall cycle counter (only with
//                             HAZARD_SCOREBOARD_STATS_EN defined)
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [6:0]       issue_opcode,
    input  logic [4:0]       issue_rd,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic             stall,
    output logic [NREG-1:0]  busy
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    logic [NREG-1:0]  pend_vec;
    logic [LAT_W-1:0] cnt_vec [NREG];
    logic             issue_en;

    // An issue presented while stalled is not a real issue.
    assign issue_en = issue_valid && !stall && (issue_rd != 5'd0) && writes_rd(issue_opcode);

    assign pend_vec[0] = 1'b0;
    assign cnt_vec[0]  = '0;

    for (genvar g = 1; g < NREG; g++) begin : g_entry
        sb_entry #(
            .LAT_W   (LAT_W)
        ) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .set     (issue_en && (issue_rd == 5'(g))),
            .set_lat (issue_lat),
            .clr     (wb_valid && (wb_rd == 5'(g))),
            .flush   (flush),
            .pending (pend_vec[g]),
            .cnt     (cnt_vec[g])
        );
    end

    always_comb begin
        stall = 1'b0;
        if (rs1_used && (rs1_addr != 5'd0) && pend_vec[rs1_addr] && (cnt_vec[rs1_addr] != '0)) begin
            stall = 1'b1;
        end
        if (rs2_used && (rs2_addr != 5'd0) && pend_vec[rs2_addr] && (cnt_vec[rs2_addr] != '0)) begin
            stall = 1'b1;
        end
    end

    assign busy = pend_vec;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, stall};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed scenarios followed by random traffic, all checked against a
//   per-register pending/countdown model kept in this bench.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [6:0]  issue_opcode;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_lat;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_used, rs2_used;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic [31:0] busy;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: one pending flag and one remaining-latency count per register.
    bit          m_pend [32];
    int          m_cnt  [32];
    int unsigned m_stalls;
    bit          last_stall;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREG         (32),
        .LAT_W        (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_opcode (issue_opcode),
        .issue_rd     (issue_rd),
        .issue_lat    (issue_lat),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy)
`ifdef HAZARD_SCOREBOARD_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_hazard(input int r, input bit used);
        return used && (r != 0) && m_pend[r] && (m_cnt[r] != 0);
    endfunction

    // One clock cycle: drive at the falling edge, check stall before the
    // rising edge, advance the model, check registered outputs after it.
    task automatic step(input bit r, input bit iv, input logic [6:0] opc, input int rd,
                        input int lat, input int r1, input bit u1, input int r2,
                        input bit u2, input bit wb, input int wrd, input bit fl);
        bit          ms;
        bit          iss;
        bit          np [32];
        int          nc [32];
        logic [31:0] exp_busy;
        rst_n        = r;
        issue_valid  = iv;
        issue_opcode = opc;
        issue_rd     = 5'(rd);
        issue_lat    = 3'(lat);
        rs1_addr     = 5'(r1);
        rs1_used     = u1;
        rs2_addr     = 5'(r2);
        rs2_used     = u2;
        wb_valid     = wb;
        wb_rd        = 5'(wrd);
        flush        = fl;
        #1;
        ms = model_hazard(r1, u1) || model_hazard(r2, u2);
        last_stall = stall;
        chk("stall", 32'(stall), 32'(ms));
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 32; i++) begin
                m_pend[i] = 1'b0;
                m_cnt[i]  = 0;
            end
            m_stalls = 0;
        end else begin
            if (ms) m_stalls++;
            for (int i = 0; i < 32; i++) begin
                np[i] = m_pend[i];
                nc[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
            if (wb && wrd != 0) np[wrd] = 1'b0;
            if (fl) begin
                for (int i = 0; i < 32; i++) begin
                    if (m_pend[i] && m_cnt[i] != 0) np[i] = 1'b0;
                end
            end
            iss = iv && !ms && rd != 0 && opc != OP_STORE && opc != OP_BRANCH;
            if (iss && !fl) begin
                np[rd] = 1'b1;
                nc[rd] = lat;
            end
            for (int i = 0; i < 32; i++) begin
                m_pend[i] = np[i];
                m_cnt[i]  = nc[i];
            end
        end
        #1;
        for (int i = 0; i < 32; i++) exp_busy[i] = m_pend[i];
        chk("busy", busy, exp_busy);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        chk("stall_cycles", stall_cycles, m_stalls);
`endif
        @(negedge clk);
    endtask

    task automatic issue_op(input logic [6:0] opc, input int rd, input int lat);
        step(1, 1, opc, rd, lat, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle_wb(input int wrd);
        step(1, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, wrd, 0);
    endtask

    // Load to rd, then a dependent ALU op held for one stall cycle, then retire.
    task automatic load_use(input int rd);
        issue_op(OP_LOAD, rd, 1);
        step(1, 1, OP_ALU, 6, 0, rd, 1, 0, 0, 0, 0, 0);
        chk("ld_use_stall_first", 32'(last_stall), 32'd1);
        chk("ld_use_busy_pending", 32'(busy[rd]), 32'd1);
        step(1, 1, OP_ALU, 6, 0, rd, 1, 0, 0, 0, 0, 0);
        chk("ld_use_stall_second", 32'(last_stall), 32'd0);
        chk("ld_use_busy_held", 32'(busy[rd]), 32'd1);
        idle_wb(rd);
        chk("ld_use_busy_retired", 32'(busy[rd]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; issue_valid = 1'b0; issue_opcode = OP_ALU; issue_rd = '0;
        issue_lat = '0; rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        m_stalls = 0;
        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 1'b0;
            m_cnt[i]  = 0;
        end
        // First edge only brings state out of X; not checked.
        @(posedge clk);
        @(negedge clk);

        // Reset for two cycles with random inputs.
        for (int k = 0; k < 2; k++) begin
            step(0, 1'($urandom), OP_LOAD, $urandom_range(0, 31), $urandom_range(0, 7),
                 $urandom_range(0, 31), 1'($urandom), $urandom_range(0, 31), 1'($urandom),
                 1'($urandom), $urandom_range(0, 31), 1'($urandom));
        end
        chk("rst_busy", busy, 32'd0);
        step(1, 0, OP_ALU, 0, 0, 5, 1, 9, 1, 0, 0, 0);
        chk("rst_stall", 32'(last_stall), 32'd0);

        // Load-use three times from a clean reset.
        load_use(5);
        load_use(5);
        load_use(12);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        chk("stats_three_load_use", stall_cycles, 32'd3);
`endif

        // ALU result is forwardable immediately.
        issue_op(OP_ALU, 7, 0);
        step(1, 0, OP_ALU, 0, 0, 7, 1, 7, 1, 0, 0, 0);
        chk("alu_no_stall", 32'(last_stall), 32'd0);
        chk("alu_busy", 32'(busy[7]), 32'd1);

        // Store and branch do not claim their rd-shaped field.
        issue_op(OP_STORE, 3, 2);
        issue_op(OP_BRANCH, 3, 2);
        chk("store_branch_busy", 32'(busy[3]), 32'd0);

        // WAW: younger ALU write to x9 supersedes the long divide.
        issue_op(OP_ALU, 9, 4);
        issue_op(OP_ALU, 9, 0);
        step(1, 0, OP_ALU, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        chk("waw_no_stall", 32'(last_stall), 32'd0);
        idle_wb(9);
        chk("waw_busy_retired", 32'(busy[9]), 32'd0);

        // Flush drops the in-flight multiply but keeps forwardable x7.
        issue_op(OP_ALU, 10, 3);
        step(1, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("flush_busy10", 32'(busy[10]), 32'd0);
        chk("flush_keeps7", 32'(busy[7]), 32'd1);
        step(1, 0, OP_ALU, 0, 0, 10, 1, 0, 0, 0, 0, 0);
        chk("flush_no_stall", 32'(last_stall), 32'd0);

        // Same-cycle retire and issue of x4: issue wins.
        issue_op(OP_ALU, 4, 0);
        step(1, 1, OP_ALU, 4, 2, 0, 0, 0, 0, 1, 4, 0);
        chk("wb_issue_same_busy", 32'(busy[4]), 32'd1);
        step(1, 0, OP_ALU, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        chk("wb_issue_same_stall", 32'(last_stall), 32'd1);

        // Random traffic on a small register window to force collisions.
        for (int n = 0; n < 1500; n++) begin
            logic [6:0] opc;
            case ($urandom_range(0, 5))
                0, 1:    opc = OP_ALU;
                2, 3:    opc = OP_LOAD;
                4:       opc = OP_STORE;
                default: opc = OP_BRANCH;
            endcase
            step(($urandom_range(0, 199) != 0), 1'($urandom), opc, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom),
                 $urandom_range(0, 7), 1'($urandom), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 7), ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
